// File: rtl/timer_control.sv
// Countdown timer controller: turns debounced set/start button levels into load and
// decrement strobes for an external BCD down-counter, and raises an alarm on expiry.
// All outputs are registered, so a button edge sampled in one cycle shows up in the next.
// Optional build macro: TIMER_CONTROL_BCD_CLAMP_EN clamps each entered BCD digit to 9.
module timer_control #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       setPressed,
  input  logic       startPressed,
  input  logic [7:0] digitsIn,
  input  logic [7:0] timeIn,
  output logic       writeEnable,
  output logic [7:0] inputTime,
  output logic       decrementEnable,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          set_prev_q, start_prev_q;
  logic          we_q, we_d;
  logic          dec_q, dec_d;
  logic [7:0]    time_q, time_d;
  logic          running_q, alarm_q;

  logic          set_edge, start_edge, tc, time_zero;
  logic [PW-1:0] presc_next;

  // Value presented on inputTime for a load.
  function automatic logic [7:0] load_value(input logic [7:0] d);
`ifdef TIMER_CONTROL_BCD_CLAMP_EN
    logic [3:0] hi, lo;
    hi = (d[7:4] > 4'd9) ? 4'd9 : d[7:4];
    lo = (d[3:0] > 4'd9) ? 4'd9 : d[3:0];
    return {hi, lo};
`else
    return d;
`endif
  endfunction

  // Set wins over start when both rise together.
  assign set_edge   = setPressed & ~set_prev_q;
  assign start_edge = startPressed & ~start_prev_q & ~set_edge;
  assign tc         = (presc_q == PW'(TICK_DIV - 1));
  assign presc_next = tc ? '0 : presc_q + PW'(1);
  assign time_zero  = (timeIn == 8'h00);

  // Next-state, prescaler, alarm counter and strobe decisions.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    we_d    = 1'b0;
    dec_d   = 1'b0;
    time_d  = time_q;
    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        acnt_d  = '0;
        if (set_edge) begin
          we_d   = 1'b1;
          time_d = load_value(digitsIn);
        end else if (start_edge && !time_zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (time_zero) begin
          // Expired: restart the prescaler so the alarm lasts whole ticks.
          state_d = StAlarm;
          presc_d = '0;
          acnt_d  = '0;
        end else if (start_edge) begin
          state_d = StPause;
        end else begin
          presc_d = presc_next;
          dec_d   = tc;
        end
      end
      StPause: begin
        if (set_edge) begin
          we_d    = 1'b1;
          time_d  = load_value(digitsIn);
          state_d = StIdle;
        end else if (start_edge) begin
          state_d = time_zero ? StIdle : StRun;
        end
      end
      StAlarm: begin
        if (set_edge || start_edge) begin
          state_d = StIdle;
        end else begin
          presc_d = presc_next;
          if (tc) begin
            if (acnt_q == AW'(ALARM_TICKS - 1)) begin
              state_d = StIdle;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; previous levels reset high so held buttons give no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      acnt_q       <= '0;
      set_prev_q   <= 1'b1;
      start_prev_q <= 1'b1;
      we_q         <= 1'b0;
      dec_q        <= 1'b0;
      time_q       <= 8'h00;
      running_q    <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      acnt_q       <= acnt_d;
      set_prev_q   <= setPressed;
      start_prev_q <= startPressed;
      we_q         <= we_d;
      dec_q        <= dec_d;
      time_q       <= time_d;
      running_q    <= (state_d == StRun);
      alarm_q      <= (state_d == StAlarm);
    end
  end

  assign writeEnable     = we_q;
  assign decrementEnable = dec_q;
  assign inputTime       = time_q;
  assign running         = running_q;
  assign alarm           = alarm_q;

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with TICK_DIV=4, ALARM_TICKS=2 and a small BCD
// down-counter model closing the timeIn loop.
module tb_timer_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       setPressed = 1'b0;
  logic       startPressed = 1'b0;
  logic [7:0] digitsIn = 8'h00;
  logic [7:0] timeIn;
  logic       writeEnable;
  logic [7:0] inputTime;
  logic       decrementEnable;
  logic       running;
  logic       alarm;

  logic [7:0] cnt = 8'h00;
  int checks = 0;
  int failures = 0;

  timer_control #(
    .TICK_DIV   (4),
    .ALARM_TICKS(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .setPressed     (setPressed),
    .startPressed   (startPressed),
    .digitsIn       (digitsIn),
    .timeIn         (timeIn),
    .writeEnable    (writeEnable),
    .inputTime      (inputTime),
    .decrementEnable(decrementEnable),
    .running        (running),
    .alarm          (alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00) return 8'h00;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Downstream counter model.
  always @(posedge clk) begin
    if (writeEnable) cnt <= inputTime;
    else if (decrementEnable) cnt <= bcd_dec(cnt);
  end
  assign timeIn = cnt;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({writeEnable, decrementEnable, running, alarm} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {writeEnable, decrementEnable, running, alarm});
    end
    checks++;
    if (inputTime !== 8'h00) begin
      failures++;
      $display("FAIL reset_inputTime got=%h want=00", inputTime);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({writeEnable, running} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset got=%b want=00", {writeEnable, running});
    end
  endtask

  task automatic test_load_run();
    digitsIn = 8'h12;
    setPressed = 1'b1;
    tick();
    checks++;
    if (writeEnable !== 1'b1 || inputTime !== 8'h12) begin
      failures++;
      $display("FAIL load_strobe got we=%b it=%h want we=1 it=12", writeEnable, inputTime);
    end
    setPressed = 1'b0;
    tick();
    checks++;
    if (writeEnable !== 1'b0 || cnt !== 8'h12) begin
      failures++;
      $display("FAIL load_one_cycle got we=%b cnt=%h want we=0 cnt=12", writeEnable, cnt);
    end
    startPressed = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1 || decrementEnable !== 1'b0) begin
      failures++;
      $display("FAIL run_start got run=%b dec=%b want run=1 dec=0", running, decrementEnable);
    end
    startPressed = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (decrementEnable !== ((i % 4) == 0)) begin
        failures++;
        $display("FAIL run_dec cycle=%0d got=%b want=%b", i, decrementEnable, (i % 4) == 0);
      end
    end
    tick();
    checks++;
    if (cnt !== 8'h09) begin
      failures++;
      $display("FAIL run_count got=%h want=09", cnt);
    end
  endtask

  task automatic test_pause();
    tick();
    startPressed = 1'b1;
    tick();
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL pause_enter got run=%b want 0", running);
    end
    startPressed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (decrementEnable !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold cycle=%0d got dec=%b run=%b want 0 0", i, decrementEnable,
                 running);
      end
    end
    startPressed = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1 || decrementEnable !== 1'b0) begin
      failures++;
      $display("FAIL resume got run=%b dec=%b want run=1 dec=0", running, decrementEnable);
    end
    startPressed = 1'b0;
    tick();
    checks++;
    if (decrementEnable !== 1'b0) begin
      failures++;
      $display("FAIL resume_phase1 got=%b want=0", decrementEnable);
    end
    tick();
    checks++;
    if (decrementEnable !== 1'b1) begin
      failures++;
      $display("FAIL resume_phase2 got=%b want=1", decrementEnable);
    end
    tick();
    checks++;
    if (cnt !== 8'h08) begin
      failures++;
      $display("FAIL resume_count got=%h want=08", cnt);
    end
  endtask

  task automatic test_expiry();
    startPressed = 1'b1;
    tick();
    startPressed = 1'b0;
    digitsIn = 8'h01;
    setPressed = 1'b1;
    tick();
    checks++;
    if (writeEnable !== 1'b1 || inputTime !== 8'h01 || running !== 1'b0) begin
      failures++;
      $display("FAIL pause_set got we=%b it=%h run=%b want 1 01 0", writeEnable, inputTime,
               running);
    end
    setPressed = 1'b0;
    tick();
    startPressed = 1'b1;
    tick();
    startPressed = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks++;
      if (decrementEnable !== (i == 4) || alarm !== (i >= 6 && i <= 13) ||
          running !== (i <= 5)) begin
        failures++;
        $display("FAIL expiry cycle=%0d got dec=%b alarm=%b run=%b want %b %b %b", i,
                 decrementEnable, alarm, running, i == 4, i >= 6 && i <= 13, i <= 5);
      end
    end
  endtask

  task automatic test_alarm_ack();
    startPressed = 1'b1;
    tick();
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL start_at_zero got run=%b want 0", running);
    end
    startPressed = 1'b0;
    tick();
    digitsIn = 8'h01;
    setPressed = 1'b1;
    tick();
    setPressed = 1'b0;
    tick();
    startPressed = 1'b1;
    tick();
    startPressed = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (alarm !== 1'b1) begin
      failures++;
      $display("FAIL alarm_on got=%b want=1", alarm);
    end
    digitsIn = 8'h33;
    setPressed = 1'b1;
    tick();
    checks++;
    if (alarm !== 1'b0 || writeEnable !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL alarm_ack got alarm=%b we=%b run=%b want 0 0 0", alarm, writeEnable,
               running);
    end
    setPressed = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    digitsIn = 8'h05;
    setPressed = 1'b1;
    startPressed = 1'b1;
    tick();
    checks++;
    if (writeEnable !== 1'b1 || inputTime !== 8'h05 || running !== 1'b0) begin
      failures++;
      $display("FAIL simul got we=%b it=%h run=%b want 1 05 0", writeEnable, inputTime, running);
    end
    setPressed = 1'b0;
    startPressed = 1'b0;
    tick();
    tick();
    checks++;
    if (running !== 1'b0 || writeEnable !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle got run=%b we=%b want 0 0", running, writeEnable);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] want;
`ifdef TIMER_CONTROL_BCD_CLAMP_EN
    want = 8'h99;
`else
    want = 8'hAF;
`endif
    digitsIn = 8'hAF;
    setPressed = 1'b1;
    tick();
    checks++;
    if (writeEnable !== 1'b1 || inputTime !== want) begin
      failures++;
      $display("FAIL clamp got we=%b it=%h want we=1 it=%h", writeEnable, inputTime, want);
    end
    setPressed = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    digitsIn = 8'h03;
    setPressed = 1'b1;
    tick();
    setPressed = 1'b0;
    tick();
    startPressed = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_run got=%b want=1", running);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({writeEnable, decrementEnable, running, alarm} !== 4'b0000 || inputTime !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got flags=%b it=%h want 0000 00",
               {writeEnable, decrementEnable, running, alarm}, inputTime);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (running !== 1'b0 || decrementEnable !== 1'b0) begin
        failures++;
        $display("FAIL held_start cycle=%0d got run=%b dec=%b want 0 0", i, running,
                 decrementEnable);
      end
    end
    startPressed = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_pause();
    test_expiry();
    test_alarm_ack();
    test_simultaneous();
    test_clamp();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
